// File: rtl/rvx_spi_boot_loader.sv
// Power-up boot sequencer: issues one SPI NOR READ (0x03) burst, packs the returned
// bytes into little-endian words, writes them to memory, then releases the rvx core.
module rvx_spi_boot_loader #(
    parameter int          SCLK_DIVIDER        = 4,
    parameter logic [23:0] FLASH_START_ADDRESS = 24'h000000,
    parameter int          IMAGE_SIZE          = 8192,
    parameter logic [31:0] BOOT_ADDRESS        = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        sclk,
    output logic        pico,
    input  logic        poci,
    output logic        cs,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_strobe,
    output logic        mem_write_request,
    input  logic        mem_write_response,
    output logic        cpu_reset,
    output logic        boot_done
);
    localparam int             WORDS     = IMAGE_SIZE / 4;
    localparam int             WCW       = (WORDS < 2) ? 1 : $clog2(WORDS + 1);
    localparam logic [7:0]     DIV_LAST  = 8'(SCLK_DIVIDER - 1);
    localparam logic [31:0]    CMD_WORD  = {8'h03, FLASH_START_ADDRESS};
    localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);
    localparam logic [WCW-1:0] WORD_ONE  = WCW'(1);

    typedef enum logic [2:0] {
        IDLE, CS_SETUP, SHIFT_CMD, SHIFT_DATA, MEM_WRITE, CS_HOLD, DONE
    } state_t;

    state_t         state_q;
    logic [7:0]     div_q;
    logic [4:0]     bit_q;
    logic [WCW-1:0] word_q;
    logic           sclk_q;
    logic           pico_q;
    logic           cs_q;
    logic           req_q;
    logic [3:0]     strobe_q;
    logic [31:0]    addr_q;
    logic [31:0]    data_q;
    logic           cpu_reset_q;
    logic           boot_done_q;

    logic           div_end_d;
    logic [4:0]     bit_d;
    logic [4:0]     data_idx_d;

    // Divider phase end, next bit number and little-endian bit position of the current data bit
    always_comb begin
        div_end_d  = (div_q == DIV_LAST);
        bit_d      = bit_q + 5'd1;
        data_idx_d = {bit_q[4:3], ~bit_q[2:0]};
    end

    // Boot sequencer with all SPI, memory and core-control outputs registered
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            div_q       <= 8'd0;
            bit_q       <= 5'd0;
            word_q      <= '0;
            sclk_q      <= 1'b0;
            pico_q      <= 1'b0;
            cs_q        <= 1'b1;
            req_q       <= 1'b0;
            strobe_q    <= 4'h0;
            addr_q      <= BOOT_ADDRESS;
            data_q      <= 32'h0000_0000;
            cpu_reset_q <= 1'b1;
            boot_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    div_q <= 8'd0;
                    if (WORDS == 0) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= CS_SETUP;
                        cs_q    <= 1'b0;
                    end
                end
                CS_SETUP: begin
                    if (div_end_d) begin
                        state_q <= SHIFT_CMD;
                        div_q   <= 8'd0;
                        bit_q   <= 5'd0;
                        pico_q  <= CMD_WORD[31];
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                SHIFT_CMD, SHIFT_DATA: begin
                    if (!div_end_d) begin
                        div_q <= div_q + 8'd1;
                    end else begin
                        div_q <= 8'd0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            if (state_q == SHIFT_DATA) begin
                                data_q[data_idx_d] <= poci;
                            end
                        end else begin
                            // bit_q wraps to 0 after bit 31, ready for the next 32-bit run
                            sclk_q <= 1'b0;
                            bit_q  <= bit_d;
                            if (bit_q != 5'd31) begin
                                pico_q <= (state_q == SHIFT_CMD) ? CMD_WORD[~bit_d] : 1'b0;
                            end else if (state_q == SHIFT_CMD) begin
                                state_q <= SHIFT_DATA;
                                pico_q  <= 1'b0;
                            end else begin
                                state_q  <= MEM_WRITE;
                                pico_q   <= 1'b0;
                                req_q    <= 1'b1;
                                strobe_q <= 4'hF;
                            end
                        end
                    end
                end
                MEM_WRITE: begin
                    if (mem_write_response) begin
                        req_q    <= 1'b0;
                        strobe_q <= 4'h0;
                        addr_q   <= addr_q + 32'd4;
                        word_q   <= word_q + WORD_ONE;
                        div_q    <= 8'd0;
                        bit_q    <= 5'd0;
                        if (word_q == LAST_WORD) begin
                            state_q <= CS_HOLD;
                            cs_q    <= 1'b1;
                        end else begin
                            state_q <= SHIFT_DATA;
                        end
                    end
                end
                CS_HOLD: begin
                    if (div_end_d) begin
                        state_q <= DONE;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                DONE: begin
                    boot_done_q <= 1'b1;
                    cpu_reset_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sclk              = sclk_q;
    assign pico              = pico_q;
    assign cs                = cs_q;
    assign mem_address       = addr_q;
    assign mem_write_data    = data_q;
    assign mem_write_strobe  = strobe_q;
    assign mem_write_request = req_q;
    assign cpu_reset         = cpu_reset_q;
    assign boot_done         = boot_done_q;

endmodule

// File: tb/tb_rvx_spi_boot_loader.sv
// Self-checking bench: three loader configurations driven by a behavioural SPI NOR flash
// and write-port model; expectations come from byte images and the boot-latency formula.
module tb_rvx_spi_boot_loader;
    localparam int          A_DIV  = 2;
    localparam int          A_SIZE = 8;
    localparam logic [23:0] A_FSA  = 24'h010000;
    localparam logic [31:0] A_BOOT = 32'h0000_0000;
    localparam int          A_LAT  = A_DIV * (2 + 2 * (32 + 8 * A_SIZE)) + A_SIZE / 4 + 2;
    localparam int          F_DIV  = 1;
    localparam int          F_SIZE = 4;
    localparam logic [23:0] F_FSA  = 24'hABCDEF;
    localparam logic [31:0] F_BOOT = 32'hFFFF_FFFC;
    localparam int          F_LAT  = F_DIV * (2 + 2 * (32 + 8 * F_SIZE)) + F_SIZE / 4 + 2;

    logic clock = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic        a_rst = 1'b1, a_poci = 1'b0, a_resp = 1'b0;
    logic        a_sclk, a_pico, a_cs, a_req, a_cpu, a_done;
    logic [31:0] a_addr, a_data;
    logic [3:0]  a_strb;
    logic        z_rst = 1'b1, z_poci = 1'b0, z_resp = 1'b0;
    logic        z_sclk, z_pico, z_cs, z_req, z_cpu, z_done;
    logic [31:0] z_addr, z_data;
    logic [3:0]  z_strb;
    logic        f_rst = 1'b1, f_poci = 1'b0, f_resp = 1'b1;
    logic        f_sclk, f_pico, f_cs, f_req, f_cpu, f_done;
    logic [31:0] f_addr, f_data;
    logic [3:0]  f_strb;

    rvx_spi_boot_loader #(.SCLK_DIVIDER(A_DIV), .FLASH_START_ADDRESS(A_FSA),
                          .IMAGE_SIZE(A_SIZE), .BOOT_ADDRESS(A_BOOT)) u_main (
        .clock(clock), .reset(a_rst), .sclk(a_sclk), .pico(a_pico), .poci(a_poci), .cs(a_cs),
        .mem_address(a_addr), .mem_write_data(a_data), .mem_write_strobe(a_strb),
        .mem_write_request(a_req), .mem_write_response(a_resp), .cpu_reset(a_cpu), .boot_done(a_done));

    rvx_spi_boot_loader #(.SCLK_DIVIDER(3), .FLASH_START_ADDRESS(24'h000000),
                          .IMAGE_SIZE(0), .BOOT_ADDRESS(32'h0000_0000)) u_zero (
        .clock(clock), .reset(z_rst), .sclk(z_sclk), .pico(z_pico), .poci(z_poci), .cs(z_cs),
        .mem_address(z_addr), .mem_write_data(z_data), .mem_write_strobe(z_strb),
        .mem_write_request(z_req), .mem_write_response(z_resp), .cpu_reset(z_cpu), .boot_done(z_done));

    rvx_spi_boot_loader #(.SCLK_DIVIDER(F_DIV), .FLASH_START_ADDRESS(F_FSA),
                          .IMAGE_SIZE(F_SIZE), .BOOT_ADDRESS(F_BOOT)) u_fast (
        .clock(clock), .reset(f_rst), .sclk(f_sclk), .pico(f_pico), .poci(f_poci), .cs(f_cs),
        .mem_address(f_addr), .mem_write_data(f_data), .mem_write_strobe(f_strb),
        .mem_write_request(f_req), .mem_write_response(f_resp), .cpu_reset(f_cpu), .boot_done(f_done));

    initial forever #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Flash models: capture the command on rising sclk, present the next image bit after each fall
    logic [7:0]  a_img [0:A_SIZE-1];
    logic [31:0] a_cmd = 32'h0, a_lastcmd = 32'h0;
    int          a_rise = 0, a_tot = 0;
    initial forever begin
        @(posedge a_sclk or negedge a_sclk or posedge a_cs);
        if (a_cs === 1'b1) begin
            a_rise = 0; a_cmd = 32'h0; a_poci = 1'b0;
        end else if (a_sclk === 1'b1) begin
            if (a_rise < 32) a_cmd = {a_cmd[30:0], a_pico};
            a_rise++; a_tot++;
            if (a_rise == 32) a_lastcmd = a_cmd;
        end else if (a_rise >= 32 && a_rise < 32 + 8 * A_SIZE) begin
            a_poci = a_img[(a_rise - 32) / 8][7 - (a_rise - 32) % 8];
        end
    end

    logic [7:0]  f_img [0:F_SIZE-1];
    logic [31:0] f_cmd = 32'h0, f_lastcmd = 32'h0;
    int          f_rise = 0, f_tot = 0, f_last = -1, f_gmin = 1000, f_gmax = 0;
    initial forever begin
        @(posedge f_sclk or negedge f_sclk or posedge f_cs);
        if (f_cs === 1'b1) begin
            f_rise = 0; f_cmd = 32'h0; f_poci = 1'b0;
        end else if (f_sclk === 1'b1) begin
            if (f_rise < 32) f_cmd = {f_cmd[30:0], f_pico};
            f_rise++; f_tot++;
            if (f_rise == 32) f_lastcmd = f_cmd;
            if (f_last >= 0 && cyc - f_last < f_gmin) f_gmin = cyc - f_last;
            if (f_last >= 0 && cyc - f_last > f_gmax) f_gmax = cyc - f_last;
            f_last = cyc;
        end else if (f_rise >= 32 && f_rise < 32 + 8 * F_SIZE) begin
            f_poci = f_img[(f_rise - 32) / 8][7 - (f_rise - 32) % 8];
        end
    end

    // Memory models: respond after a_delay wait cycles, log accepted writes and protocol slips
    int          a_delay = 0, a_hold = 0, a_unstable = 0, a_badreq = 0;
    bit          a_free = 1'b0;
    logic [31:0] a_pa, a_pd;
    logic [31:0] a_wa[$], a_wd[$], f_wa[$], f_wd[$];
    int          a_wh[$];
    initial forever begin
        @(negedge clock);
        if (!a_free) begin
            if (a_req === 1'b1) begin
                a_hold++;
                if (a_sclk !== 1'b0 || a_cs !== 1'b0 || a_strb !== 4'hF) a_badreq++;
                if (a_hold > 1 && (a_addr !== a_pa || a_data !== a_pd)) a_unstable++;
                a_pa = a_addr; a_pd = a_data;
                a_resp = (a_hold > a_delay);
                if (a_resp) begin
                    a_wa.push_back(a_addr); a_wd.push_back(a_data); a_wh.push_back(a_hold);
                    a_hold = 0;
                end
            end else begin
                a_resp = 1'b0; a_hold = 0;
                if (a_strb !== 4'h0) a_badreq++;
            end
        end
    end

    int z_csl = 0, z_sclkhi = 0, z_reqhi = 0;
    initial forever begin
        @(negedge clock);
        if (z_cs !== 1'b1) z_csl++;
        if (z_sclk !== 1'b0) z_sclkhi++;
        if (z_req !== 1'b0) z_reqhi++;
        if (f_req === 1'b1 && f_resp === 1'b1) begin
            f_wa.push_back(f_addr); f_wd.push_back(f_data);
        end
    end

    task automatic a_clear;
        a_wa.delete(); a_wd.delete(); a_wh.delete();
        a_tot = 0; a_badreq = 0; a_unstable = 0; a_lastcmd = 32'h0;
    endtask

    // Releases main reset at the current negedge and returns cycles until cpu_reset drops
    task automatic a_boot(output int lat);
        int t0;
        a_rst = 1'b0; t0 = cyc; lat = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (a_cpu === 1'b0) begin lat = cyc - t0; break; end
        end
    endtask

    task automatic test_reset;
        a_rst = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({a_cs, a_sclk, a_pico, a_req, a_strb, a_cpu, a_done} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b expected 1000000010", {a_cs, a_sclk, a_pico, a_req, a_strb, a_cpu, a_done});
        end
        n_cmp++;
        if (a_addr !== A_BOOT) begin n_bad++; $display("FAIL reset_addr: got %h expected %h", a_addr, A_BOOT); end
        n_cmp++;
        if (a_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", a_data); end
    endtask

    task automatic test_zero_wait;
        logic [31:0] spec_words [0:1];
        int lat;
        spec_words[0] = 32'h0000_0013; spec_words[1] = 32'h0000_006F;
        a_img[0] = 8'h13; a_img[1] = 8'h00; a_img[2] = 8'h00; a_img[3] = 8'h00;
        a_img[4] = 8'h6F; a_img[5] = 8'h00; a_img[6] = 8'h00; a_img[7] = 8'h00;
        a_delay = 0; a_rst = 1'b1;
        repeat (2) @(negedge clock);
        a_clear();
        a_boot(lat);
        n_cmp++;
        if (lat != A_LAT) begin n_bad++; $display("FAIL zw_latency: got %0d expected %0d", lat, A_LAT); end
        n_cmp++;
        if (a_lastcmd !== {8'h03, A_FSA}) begin n_bad++; $display("FAIL zw_command: got %h expected %h", a_lastcmd, {8'h03, A_FSA}); end
        n_cmp++;
        if (a_wa.size() != 2) begin n_bad++; $display("FAIL zw_write_count: got %0d expected 2", a_wa.size()); end
        for (int w = 0; w < 2 && w < a_wa.size(); w++) begin
            n_cmp++;
            if (a_wa[w] !== A_BOOT + 32'(4 * w) || a_wd[w] !== spec_words[w]) begin
                n_bad++;
                $display("FAIL zw_write%0d: got %h@%h expected %h@%h", w, a_wd[w], a_wa[w], spec_words[w], A_BOOT + 32'(4 * w));
            end
        end
        n_cmp++;
        if (a_tot != 32 + 8 * A_SIZE) begin n_bad++; $display("FAIL zw_sclk_rises: got %0d expected %0d", a_tot, 32 + 8 * A_SIZE); end
        n_cmp++;
        if (a_badreq != 0) begin n_bad++; $display("FAIL zw_request_protocol: got %0d bad cycles expected 0", a_badreq); end
        n_cmp++;
        if ({a_cs, a_done, a_cpu} !== 3'b110) begin n_bad++; $display("FAIL zw_final: got cs/done/cpu %b expected 110", {a_cs, a_done, a_cpu}); end
    endtask

    task automatic test_wait_states;
        int lat;
        a_delay = 5; a_rst = 1'b1;
        repeat (2) @(negedge clock);
        a_clear();
        a_boot(lat);
        n_cmp++;
        if (lat != A_LAT + 5 * (A_SIZE / 4)) begin n_bad++; $display("FAIL ws_latency: got %0d expected %0d", lat, A_LAT + 5 * (A_SIZE / 4)); end
        n_cmp++;
        if (a_wa.size() != A_SIZE / 4) begin n_bad++; $display("FAIL ws_write_count: got %0d expected %0d", a_wa.size(), A_SIZE / 4); end
        for (int w = 0; w < a_wa.size(); w++) begin
            n_cmp++;
            if (a_wd[w] !== {a_img[4*w+3], a_img[4*w+2], a_img[4*w+1], a_img[4*w]} || a_wa[w] !== A_BOOT + 32'(4 * w) || a_wh[w] != 6) begin
                n_bad++;
                $display("FAIL ws_write%0d: got %h@%h held %0d expected %h@%h held 6", w, a_wd[w], a_wa[w], a_wh[w],
                         {a_img[4*w+3], a_img[4*w+2], a_img[4*w+1], a_img[4*w]}, A_BOOT + 32'(4 * w));
            end
        end
        n_cmp++;
        if (a_unstable != 0 || a_badreq != 0) begin
            n_bad++; $display("FAIL ws_stability: got %0d unstable %0d bad expected 0 0", a_unstable, a_badreq);
        end
    endtask

    task automatic test_reset_midway;
        int lat;
        bit reached;
        for (int i = 0; i < A_SIZE; i++) a_img[i] = 8'($urandom);
        a_delay = int'($urandom_range(0, 3)); a_rst = 1'b1;
        repeat (2) @(negedge clock);
        a_rst = 1'b0; reached = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (a_rise >= 32 + 19) begin reached = 1'b1; break; end
        end
        n_cmp++;
        if (!reached) begin n_bad++; $display("FAIL rm_reach_byte3: got rise %0d expected >= 51", a_rise); end
        a_rst = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({a_cs, a_cpu, a_sclk, a_req} !== 4'b1100) begin n_bad++; $display("FAIL rm_reset_outputs: got %b expected 1100", {a_cs, a_cpu, a_sclk, a_req}); end
        a_clear();
        a_boot(lat);
        n_cmp++;
        if (lat != A_LAT + a_delay * (A_SIZE / 4)) begin n_bad++; $display("FAIL rm_latency: got %0d expected %0d", lat, A_LAT + a_delay * (A_SIZE / 4)); end
        n_cmp++;
        if (a_lastcmd !== {8'h03, A_FSA}) begin n_bad++; $display("FAIL rm_command: got %h expected %h", a_lastcmd, {8'h03, A_FSA}); end
        n_cmp++;
        if (a_wa.size() != A_SIZE / 4) begin n_bad++; $display("FAIL rm_write_count: got %0d expected %0d", a_wa.size(), A_SIZE / 4); end
        for (int w = 0; w < a_wa.size(); w++) begin
            n_cmp++;
            if (a_wd[w] !== {a_img[4*w+3], a_img[4*w+2], a_img[4*w+1], a_img[4*w]} || a_wa[w] !== A_BOOT + 32'(4 * w)) begin
                n_bad++;
                $display("FAIL rm_write%0d: got %h@%h expected %h@%h", w, a_wd[w], a_wa[w],
                         {a_img[4*w+3], a_img[4*w+2], a_img[4*w+1], a_img[4*w]}, A_BOOT + 32'(4 * w));
            end
        end
    endtask

    task automatic test_after_done;
        logic [73:0] snap, now_v;
        int changes;
        changes = 0;
        snap = {a_sclk, a_pico, a_cs, a_addr, a_data, a_strb, a_req, a_cpu, a_done};
        a_free = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            now_v = {a_sclk, a_pico, a_cs, a_addr, a_data, a_strb, a_req, a_cpu, a_done};
            if (now_v !== snap) changes++;
            a_poci = 1'($urandom); a_resp = 1'($urandom);
        end
        a_free = 1'b0; a_resp = 1'b0; a_poci = 1'b0;
        n_cmp++;
        if (changes != 0) begin n_bad++; $display("FAIL done_outputs_constant: got %0d changed cycles expected 0", changes); end
        n_cmp++;
        if ({a_done, a_cpu, a_cs} !== 3'b101) begin n_bad++; $display("FAIL done_state: got done/cpu/cs %b expected 101", {a_done, a_cpu, a_cs}); end
    endtask

    task automatic test_zero_image;
        z_rst = 1'b1;
        repeat (2) @(negedge clock);
        z_rst = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({z_done, z_cpu} !== 2'b01) begin n_bad++; $display("FAIL zi_cycle1: got done/cpu %b expected 01", {z_done, z_cpu}); end
        @(negedge clock);
        n_cmp++;
        if ({z_done, z_cpu} !== 2'b10) begin n_bad++; $display("FAIL zi_cycle2: got done/cpu %b expected 10", {z_done, z_cpu}); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            z_poci = 1'($urandom); z_resp = 1'($urandom);
        end
        n_cmp++;
        if (z_csl != 0 || z_sclkhi != 0 || z_reqhi != 0) begin
            n_bad++; $display("FAIL zi_idle_bus: got cs_low %0d sclk_high %0d req %0d expected 0 0 0", z_csl, z_sclkhi, z_reqhi);
        end
    endtask

    task automatic test_fast_divider;
        int t0, lat;
        logic [31:0] expw;
        for (int i = 0; i < F_SIZE; i++) f_img[i] = 8'($urandom);
        expw = {f_img[3], f_img[2], f_img[1], f_img[0]};
        f_rst = 1'b1;
        repeat (2) @(negedge clock);
        f_rst = 1'b0; t0 = cyc; lat = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (f_cpu === 1'b0) begin lat = cyc - t0; break; end
        end
        n_cmp++;
        if (lat != F_LAT) begin n_bad++; $display("FAIL fd_latency: got %0d expected %0d", lat, F_LAT); end
        n_cmp++;
        if (f_tot != 64) begin n_bad++; $display("FAIL fd_sclk_rises: got %0d expected 64", f_tot); end
        n_cmp++;
        if (f_gmin != 2 || f_gmax != 2) begin n_bad++; $display("FAIL fd_sclk_period: got min %0d max %0d expected 2 2", f_gmin, f_gmax); end
        n_cmp++;
        if (f_lastcmd !== {8'h03, F_FSA}) begin n_bad++; $display("FAIL fd_command: got %h expected %h", f_lastcmd, {8'h03, F_FSA}); end
        n_cmp++;
        if (f_wa.size() != 1 || f_wa[0] !== F_BOOT || f_wd[0] !== expw) begin
            n_bad++; $display("FAIL fd_write: got %0d writes first %h@%h expected 1 write %h@%h", f_wa.size(), f_wd[0], f_wa[0], expw, F_BOOT);
        end
        n_cmp++;
        if (f_addr !== 32'h0000_0000 || f_done !== 1'b1) begin
            n_bad++; $display("FAIL fd_addr_wrap: got addr %h done %b expected 00000000 1", f_addr, f_done);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_reset_midway();
        test_after_done();
        test_zero_image();
        test_fast_divider();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
